gf2m_serial_mul: RTL and testbench
==================================

Name: gf2m_serial_mul

Overview:
- Digit-serial GF(2^M) polynomial-basis multiplier. It consumes MUL_IN_VALID and operands from the point-translate/ladder control FSM, and returns MUL_OUT_VALID and ERROR to that FSM.
- Operands are latched on acceptance, so the controller may reload its T1/T2/X registers on the cycles after its one-cycle MUL_IN_VALID pulse.
- The result is held stable on C until the next result replaces it.

Parameters:
- M, 163: field degree.
- D, 1: multiplier bits consumed per cycle (1..16). The digit count is N = ceil(M/D).
- POLY, M-bit 'hC9: reduction polynomial F with the x^M term omitted. The default is x^163+x^7+x^6+x^3+1.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- MUL_IN_VALID  in  1  start pulse; A and B are sampled on the same edge.
- A  in  M  multiplicand.
- B  in  M  multiplier, scanned MSB first.
- ERR_CLR  in  1  synchronous clear of ERROR.
- C  out  M  product A*B mod F.
- MUL_OUT_VALID  out  1  one-cycle pulse marking C as new.
- BUSY  out  1  high while computing.
- ERROR  out  1  sticky error flag.

Behaviour:
- Reset (async, RST_N=0): state IDLE; C=0, MUL_OUT_VALID=0, BUSY=0, ERROR=0; internal accumulator, operand registers and counter all zero. Reset mid-operation abandons the computation; no MUL_OUT_VALID is produced afterwards.
- States:
  - IDLE: waiting for a start pulse.
  - CALC: N cycles of computation.
  - DONE: one cycle presenting the result.
- Acceptance: MUL_IN_VALID=1 at an edge while in IDLE or DONE:
  - latch A into Ar and B into Br;
  - Z <= 0, cnt <= N;
  - move to CALC.
  - Back-to-back operation is therefore legal: a start in DONE goes directly to CALC.
- CALC, each cycle:
  - take the top D bits of Br (zero-padded when M%D≠0 on the first digit);
  - Z <= (Z·x^D mod F) XOR (Ar·digit mod F);
  - shift Br left by D; cnt <= cnt-1;
  - when cnt reaches 1 this edge, move to DONE.
- DONE: C <= final Z, registered on the edge entering DONE. MUL_OUT_VALID=1 for exactly the DONE cycle. Then go to IDLE, or to CALC on a new start.
- Latency: with start sampled at edge k, MUL_OUT_VALID is high in the cycle after edge k+N. Total latency is N+1 cycles: 164 for M=163,D=1; 42 for D=4.
- BUSY = 1 exactly while in CALC.
- Protocol error: MUL_IN_VALID=1 while in CALC is ignored (the current operation continues unchanged) and sets ERROR.
- ERROR clearing: ERROR is cleared only by reset, or by ERR_CLR=1 on an edge. If a set condition and ERR_CLR occur on the same edge, set wins.
- Arithmetic: XOR/AND only, no carries. The reduction uses POLY: every bit shifted out at position M folds back in as POLY. C is always fully reduced (degree < M).

Optional Feature:
- Macro: GF2M_MUL_DUP_CHECK_EN.
- With the macro defined:
  - a second identical datapath computes B·A (operands swapped) in lockstep;
  - in the DONE cycle the two results are compared, and on mismatch ERROR is set on the same edge that raises MUL_OUT_VALID;
  - C always takes the primary datapath's result.
- Without the macro: no second datapath; ERROR arises only from protocol errors.

Decomposition:
- Package ecc_pkg:
  - field constants ECC_M=163, ECC_POLY;
  - state encoding typedef mul_state_t (IDLE=2'b00, CALC=2'b01, DONE=2'b10);
  - function digit-count helper ceil(M/D).
- Sub-module gf2m_digit_step: purely combinational, computing (Z·x^D mod F) XOR (A·digit mod F). It is instantiated once, or twice when GF2M_MUL_DUP_CHECK_EN is defined.

Test Plan:
- M=163,D=1: A=1, B=0x5A5A…(163 bit) → C=B; MUL_OUT_VALID is a single pulse 164 cycles after the start edge; BUSY high for 163 cycles.
- A=0x2 (x), B=x^162 → C=0xC9. With D=4 the same C results after 42 cycles. With D=7 (M%D≠0) the same C results.
- Start a second operation in the DONE cycle of the first (A=3,B=3 → C=0x5): both results correct, no idle gap; changing A and B the cycle after each start does not affect the result.
- MUL_IN_VALID pulsed mid-CALC → ERROR=1, current result unchanged; ERR_CLR pulse → ERROR=0.
- RST_N asserted at CALC cycle 50, released, then no further stimulus → no MUL_OUT_VALID; all outputs 0 in the same cycle RST_N falls.
- GF2M_MUL_DUP_CHECK_EN: normal run → ERROR=0. Force one bit of the secondary accumulator mid-CALC → ERROR=1 in the same cycle as MUL_OUT_VALID, with C still correct.

Source files
------------

// File: rtl/ecc_pkg.sv
// Shared field constants, FSM state encoding and digit-count helper
// for the GF(2^M) serial multiplier.
package ecc_pkg;
    localparam int ECC_M = 163;
    localparam logic [ECC_M-1:0] ECC_POLY = 163'hC9;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } mul_state_t;

    function automatic int digit_count(input int m, input int d);
        return (m + d - 1) / d;
    endfunction
endpackage

// File: rtl/gf2m_digit_step.sv
// One digit of a MSB-first polynomial-basis multiply:
// z_next = (z * x^D mod F) ^ (a * digit mod F), purely combinational.
module gf2m_digit_step #(
    parameter int M = 163,
    parameter int D = 1,
    parameter logic [M-1:0] POLY = 'hC9
) (
    input  logic [M-1:0] z,
    input  logic [M-1:0] a,
    input  logic [D-1:0] digit,
    output logic [M-1:0] z_next
);
    logic [M-1:0] acc;

    // Horner form: each bit shifts once, folds the x^M overflow back as POLY,
    // then adds A if that multiplier bit is set.
    always_comb begin
        acc = z;
        for (int i = D - 1; i >= 0; i--) begin
            acc = {acc[M-2:0], 1'b0} ^ (acc[M-1] ? POLY : '0) ^ (digit[i] ? a : '0);
        end
        z_next = acc;
    end
endmodule

// File: rtl/gf2m_serial_mul.sv
// Digit-serial GF(2^M) multiplier, N = ceil(M/D) cycles per product.
// Define GF2M_MUL_DUP_CHECK_EN to add a lockstep B*A datapath whose mismatch raises ERROR.
module gf2m_serial_mul
    import ecc_pkg::*;
#(
    parameter int M = ECC_M,
    parameter int D = 1,
    parameter logic [M-1:0] POLY = 'hC9
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         MUL_IN_VALID,
    input  logic [M-1:0] A,
    input  logic [M-1:0] B,
    input  logic         ERR_CLR,
    output logic [M-1:0] C,
    output logic         MUL_OUT_VALID,
    output logic         BUSY,
    output logic         ERROR
);
    localparam int N  = digit_count(M, D);
    localparam int W  = N * D;
    localparam int CW = $clog2(N + 1);

    mul_state_t   state;
    logic [M-1:0] ar;
    logic [M-1:0] z;
    logic [M-1:0] z_next;
    logic [W-1:0] br;
    logic [CW-1:0] cnt;
    logic         start;
    logic         last;
    logic         dup_err;

    // Multiplier is zero-extended to N*D bits so the first digit carries the padding.
    assign start = MUL_IN_VALID && (state != CALC);
    assign last  = (state == CALC) && (cnt == CW'(1));

    gf2m_digit_step #(.M(M), .D(D), .POLY(POLY)) u_step (
        .z      (z),
        .a      (ar),
        .digit  (br[W-1 -: D]),
        .z_next (z_next)
    );

`ifdef GF2M_MUL_DUP_CHECK_EN
    logic [M-1:0] ar2;
    logic [M-1:0] z2;
    logic [M-1:0] z2_next;
    logic [W-1:0] br2;

    gf2m_digit_step #(.M(M), .D(D), .POLY(POLY)) u_step2 (
        .z      (z2),
        .a      (ar2),
        .digit  (br2[W-1 -: D]),
        .z_next (z2_next)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ar2 <= '0;
            br2 <= '0;
            z2  <= '0;
        end else if (start) begin
            ar2 <= B;
            br2 <= W'(A);
            z2  <= '0;
        end else if (state == CALC) begin
            z2  <= z2_next;
            br2 <= br2 << D;
        end
    end

    assign dup_err = last && (z_next != z2_next);
`else
    assign dup_err = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state         <= IDLE;
            ar            <= '0;
            br            <= '0;
            z             <= '0;
            cnt           <= '0;
            C             <= '0;
            MUL_OUT_VALID <= 1'b0;
            BUSY          <= 1'b0;
            ERROR         <= 1'b0;
        end else begin
            MUL_OUT_VALID <= 1'b0;
            // A set condition beats a same-edge clear.
            if ((MUL_IN_VALID && state == CALC) || dup_err)
                ERROR <= 1'b1;
            else if (ERR_CLR)
                ERROR <= 1'b0;

            case (state)
                IDLE, DONE: begin
                    if (MUL_IN_VALID) begin
                        ar    <= A;
                        br    <= W'(B);
                        z     <= '0;
                        cnt   <= CW'(N);
                        state <= CALC;
                        BUSY  <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    z   <= z_next;
                    br  <= br << D;
                    cnt <= cnt - 1'b1;
                    if (last) begin
                        C             <= z_next;
                        MUL_OUT_VALID <= 1'b1;
                        BUSY          <= 1'b0;
                        state         <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gf2m_serial_mul.sv
// Randomized + directed bench for gf2m_serial_mul at D=1, D=4 and D=7 against
// a schoolbook carry-less multiply followed by long-division reduction.
module tb_gf2m_serial_mul;
    localparam int M = 163;
    localparam logic [M:0] FPOLY = {1'b1, 163'hC9};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic vin = 1'b0;
    logic err_clr = 1'b0;
    logic [M-1:0] a_in = '0;
    logic [M-1:0] b_in = '0;
    logic [M-1:0] c1, c4, c7;
    logic ov1, ov4, ov7, busy1, busy4, busy7, err1, err4, err7;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gf2m_serial_mul #(.M(M), .D(1)) d1 (.CLK(clk), .RST_N(rst_n), .MUL_IN_VALID(vin), .A(a_in), .B(b_in),
        .ERR_CLR(err_clr), .C(c1), .MUL_OUT_VALID(ov1), .BUSY(busy1), .ERROR(err1));
    gf2m_serial_mul #(.M(M), .D(4)) d4 (.CLK(clk), .RST_N(rst_n), .MUL_IN_VALID(vin), .A(a_in), .B(b_in),
        .ERR_CLR(err_clr), .C(c4), .MUL_OUT_VALID(ov4), .BUSY(busy4), .ERROR(err4));
    gf2m_serial_mul #(.M(M), .D(7)) d7 (.CLK(clk), .RST_N(rst_n), .MUL_IN_VALID(vin), .A(a_in), .B(b_in),
        .ERR_CLR(err_clr), .C(c7), .MUL_OUT_VALID(ov7), .BUSY(busy7), .ERROR(err7));

    function automatic logic [M-1:0] ref_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [2*M-2:0] p;
        p = '0;
        for (int i = 0; i < M; i++)
            if (b[i]) p = p ^ ((2*M-1)'(a) << i);
        for (int i = 2*M-2; i >= M; i--)
            if (p[i]) p = p ^ ((2*M-1)'(FPOLY) << (i - M));
        return p[M-1:0];
    endfunction

    function automatic logic [M-1:0] rnd();
        logic [191:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[M-1:0];
    endfunction

    task automatic check(input string tag, input logic [M-1:0] obs, input logic [M-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [M-1:0] a, input logic [M-1:0] b, input string tag);
        logic [M-1:0] exp, r1, r4, r7;
        int l1, l4, l7, p1, p4, p7, bz;
        exp = ref_mul(a, b);
        r1 = '0; r4 = '0; r7 = '0;
        l1 = 0; l4 = 0; l7 = 0; p1 = 0; p4 = 0; p7 = 0; bz = 0;
        @(negedge clk);
        a_in = a; b_in = b; vin = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                vin = 1'b0; a_in = rnd(); b_in = rnd();
            end
            if (busy1) bz++;
            if (ov1) begin if (p1 == 0) begin l1 = cyc; r1 = c1; end p1++; end
            if (ov4) begin if (p4 == 0) begin l4 = cyc; r4 = c4; end p4++; end
            if (ov7) begin if (p7 == 0) begin l7 = cyc; r7 = c7; end p7++; end
            if (l1 != 0 && cyc >= l1 + 2) break;
        end
        check({tag, "_c_d1"}, r1, exp);
        check({tag, "_c_d4"}, r4, exp);
        check({tag, "_c_d7"}, r7, exp);
        check({tag, "_lat_d1"}, M'(l1), M'(164));
        check({tag, "_lat_d4"}, M'(l4), M'(42));
        check({tag, "_lat_d7"}, M'(l7), M'(25));
        check({tag, "_pulses"}, M'(p1 + p4 + p7), M'(3));
        check({tag, "_busy_cycles"}, M'(bz), M'(163));
        check({tag, "_err"}, M'({err1, err4, err7}), M'(0));
        check({tag, "_idle"}, M'({busy1, busy4, busy7}), M'(0));
        check({tag, "_c_hold"}, c1, exp);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin vin = 1'b0; err_clr = 1'b0; a_in = rnd(); b_in = rnd(); end
            if (ov1) begin lat = cyc; break; end
        end
    endtask

    initial begin
        logic [167:0] pat;
        logic [M-1:0] x162, ta, tb2, ta2, tb3;
        int lat, cnt;

        repeat (2) @(negedge clk);
        check("rst_c", c1, '0);
        check("rst_valid", M'(ov1), M'(0));
        check("rst_busy", M'(busy1), M'(0));
        check("rst_err", M'(err1), M'(0));
        rst_n = 1'b1;

        pat = {21{8'h5A}};
        run_op(M'(1), pat[M-1:0], "a1_pat");
        x162 = '0; x162[M-1] = 1'b1;
        run_op(M'(2), x162, "x_x162");
        check("x_x162_c9", c1, M'(163'hC9));
        for (int k = 0; k < 3; k++) run_op(rnd(), rnd(), "rand");

        // Back-to-back: second start issued in the DONE cycle of the first.
        @(negedge clk);
        a_in = M'(3); b_in = M'(3); vin = 1'b1;
        @(posedge clk);
        wait_valid(lat);
        check("b2b_first_c", c1, M'(5));
        check("b2b_first_lat", M'(lat), M'(164));
        ta = rnd(); tb2 = rnd();
        a_in = ta; b_in = tb2; vin = 1'b1;
        @(posedge clk);
        wait_valid(lat);
        check("b2b_second_c", c1, ref_mul(ta, tb2));
        check("b2b_second_lat", M'(lat), M'(164));

        // Protocol error mid-CALC with a same-edge clear: set must win.
        ta = rnd(); tb2 = rnd();
        @(negedge clk);
        a_in = ta; b_in = tb2; vin = 1'b1;
        @(posedge clk);
        cnt = 0;
        for (int cyc = 1; cyc <= 49; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin vin = 1'b0; a_in = rnd(); b_in = rnd(); end
            cnt = cyc;
        end
        vin = 1'b1; err_clr = 1'b1;
        @(posedge clk);
        wait_valid(lat);
        check("perr_c", c1, ref_mul(ta, tb2));
        check("perr_lat", M'(lat + cnt), M'(164));
        check("perr_err", M'(err1), M'(1));
        err_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        err_clr = 1'b0;
        check("err_clr", M'(err1), M'(0));

        // Reset during CALC: outputs clear immediately, no result afterwards.
        @(negedge clk);
        a_in = rnd(); b_in = rnd(); vin = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 50; cyc++) begin
            @(negedge clk);
            if (cyc == 1) vin = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check("midrst_c", c1, '0);
        check("midrst_valid", M'(ov1), M'(0));
        check("midrst_busy", M'(busy1), M'(0));
        check("midrst_err", M'(err1), M'(0));
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            if (ov1 || ov4 || ov7) cnt++;
        end
        check("midrst_no_valid", M'(cnt), M'(0));

        run_op(rnd(), rnd(), "post_rst");

`ifdef GF2M_MUL_DUP_CHECK_EN
        ta2 = rnd(); tb3 = rnd();
        @(negedge clk);
        a_in = ta2; b_in = tb3; vin = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 50; cyc++) begin
            @(negedge clk);
            if (cyc == 1) vin = 1'b0;
        end
        d1.z2 = d1.z2 ^ M'(8);
        wait_valid(lat);
        check("dup_err_with_valid", M'(err1), M'(1));
        check("dup_c_primary", c1, ref_mul(ta2, tb3));
`else
        ta2 = '0; tb3 = '0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
